// File: rtl/pin_frame_pkg.sv
// pin_frame_pkg: shared types, default parameters and width helper for pin_frame_rx
package pin_frame_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 4;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pin_sync.sv
// pin_sync: 2-flop synchronizer for an asynchronous input pin
module pin_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/pin_frame_rx.sv
// pin_frame_rx: start/data/stop serial frame receiver with a one-entry valid/ready holding register
module pin_frame_rx
  import pin_frame_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic              valid_o,
  output logic              overrun_o
);
  localparam int CNT_W = width_of(CLKS_PER_BIT);
  localparam int IDX_W = width_of(DATA_W);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);

  rx_state_t          state, state_nx;
  logic               rx_s, tick, done, take, load, drop;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  shreg;

  pin_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx_i), .q(rx_s));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = rx_s ? IDLE : START;
      START:   state_nx = !tick ? START : (rx_s ? IDLE : DATA);
      DATA:    state_nx = (tick && idx == LAST) ? STOP : DATA;
      STOP:    state_nx = tick ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end

  // a completing frame may reuse the register in the same edge it is consumed
  always_comb begin
    tick = (cnt == '0);
    done = (state == STOP) && tick;
    take = valid_o && ready_i;
    load = done && (!valid_o || take);
    drop = done && valid_o && !take;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE:  if (!rx_s) cnt <= HALF;
        START: begin
          cnt <= tick ? FULL : cnt - 1'b1;
          if (tick) idx <= '0;
        end
        DATA: begin
          cnt <= tick ? FULL : cnt - 1'b1;
          if (tick) begin
            shreg[idx] <= rx_s;
            idx        <= (idx == LAST) ? '0 : idx + 1'b1;
          end
        end
        STOP:  if (!tick) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_o    <= '0;
      err_o     <= 1'b0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (load) begin
        data_o <= shreg;
        err_o  <= ~rx_s;
      end
      valid_o   <= load | (valid_o & ~take);
      overrun_o <= overrun_o | drop;
    end
endmodule

// File: tb/tb_pin_frame_rx.sv
// tb_pin_frame_rx: table-driven and randomized bench with a frame-level reference model
module tb_pin_frame_rx;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int LAT = 2 + 1 + CPB/2 + (DW+1)*CPB;

  logic          clk = 0, rst_n = 0, rx_i = 1, ready_i = 0;
  logic [DW-1:0] data_o;
  logic          err_o, valid_o, overrun_o;
  int            tests = 0, fails = 0, cyc = 0;
  logic          sd = 0;

  typedef struct { int at; logic [DW-1:0] d; logic e; } exp_t;
  typedef struct { logic [DW-1:0] d; logic stop; logic [DW-1:0] exp_d; logic exp_e; } vec_t;
  exp_t q[$];
  vec_t vecs[6];

  logic          m_valid = 0, m_err = 0, m_ovr = 0, md, mt;
  logic [DW-1:0] m_data = '0;

  pin_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .ready_i(ready_i),
    .data_o(data_o), .err_o(err_o), .valid_o(valid_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // frame completions are scheduled LAT cycles after each start edge; the holding register follows the handshake rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_err = 0; m_ovr = 0; m_data = '0;
      q.delete();
    end else begin
      md = (q.size() > 0) && (q[0].at == cyc + 1);
      mt = m_valid && ready_i;
      if (md) begin
        if (!m_valid || mt) begin
          m_valid = 1; m_data = q[0].d; m_err = q[0].e;
        end else m_ovr = 1;
        void'(q.pop_front());
      end else if (mt) m_valid = 0;
    end
  end

  always @(negedge clk)
    if (rst_n)
      check("outputs", 32'({valid_o, err_o, overrun_o, data_o}), 32'({m_valid, m_err, m_ovr, m_data}));

  task automatic bit_wait();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    @(posedge clk); #1;
    q.push_back('{cyc + LAT, d, ~stop});
    rx_i = 0; bit_wait();
    for (int i = 0; i < DW; i++) begin rx_i = d[i]; bit_wait(); end
    rx_i = stop; bit_wait();
    rx_i = 1; bit_wait();
  endtask

  task automatic send_and_check(input logic [DW-1:0] d, input logic stop, input logic [DW-1:0] exp_d, input logic exp_e);
    fork
      send_frame(d, stop);
      begin
        @(posedge clk); #1;
        repeat (LAT-1) @(posedge clk);
        @(negedge clk);
        check("valid_before_lat", 32'(valid_o), 32'(0));
        @(posedge clk); @(negedge clk);
        check("valid_at_lat", 32'(valid_o), 32'(1));
        check("data_at_lat", 32'(data_o), 32'(exp_d));
        check("err_at_lat", 32'(err_o), 32'(exp_e));
      end
    join
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b0};

    ready_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_values", 32'({valid_o, err_o, overrun_o, data_o}), 32'(0));
    @(posedge clk); #1 rst_n = 1;

    for (int i = 0; i < 6; i++)
      send_and_check(vecs[i].d, vecs[i].stop, vecs[i].exp_d, vecs[i].exp_e);

    // false start: line low for one cycle only
    @(posedge clk); #1 rx_i = 0;
    @(posedge clk); #1 rx_i = 1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("false_start_idle", 32'(dut.state), 32'(pin_frame_pkg::IDLE));
    check("false_start_no_valid", 32'(valid_o), 32'(0));
    send_and_check(8'h01, 1'b1, 8'h01, 1'b0);

    // overrun: second frame dropped while the first is held
    ready_i = 0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    @(negedge clk);
    check("overrun_data_kept", 32'(data_o), 32'h11);
    check("overrun_flag", 32'(overrun_o), 32'(1));
    check("overrun_valid_held", 32'(valid_o), 32'(1));
    @(posedge clk); #1 ready_i = 1;
    @(posedge clk); #1;
    check("overrun_drained", 32'(valid_o), 32'(0));
    check("overrun_data_after", 32'(data_o), 32'h11);

    // consumption on the exact completion edge of the next frame
    do_reset();
    ready_i = 0;
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (LAT-1) @(posedge clk);
        #1 ready_i = 1;
        @(posedge clk); #1 ready_i = 0;
        check("simul_data", 32'(data_o), 32'h22);
        check("simul_valid", 32'(valid_o), 32'(1));
        check("simul_no_overrun", 32'(overrun_o), 32'(0));
      end
    join
    ready_i = 1;
    repeat (3) @(posedge clk);

    // reset pulse in the middle of data bit 4
    fork
      send_frame(8'hF3, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (22) @(posedge clk);
        #3 rst_n = 0;
        #1 check("midframe_reset_outputs", 32'({valid_o, err_o, overrun_o, data_o}), 32'(0));
        #4 rst_n = 1;
      end
    join
    send_and_check(8'hFF, 1'b1, 8'hFF, 1'b0);

    // randomized frames, stop bits, gaps and consumer stalls
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          send_frame(DW'($urandom), $urandom_range(0, 3) != 0);
          repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        sd = 1;
      end
      begin
        while (!sd) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 2) != 0);
        end
      end
    join
    @(posedge clk); #1 ready_i = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("final_drained", 32'(valid_o), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
